// File: rtl/spi_slave_sync.sv
// SPI slave clocked entirely on the system clock. sclk, cs and sdi are
// oversampled through synchronisers; LSB-first frames of WIDTH bits, with
// a one-word transmit holding register and one-cycle status pulses.
module spi_slave_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs,
    input  logic             sdi,
    output logic             sdo,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, sdi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [WIDTH-1:0]       hold_data;
    logic                   hold_full;
    logic                   accept;
    logic [WIDTH-1:0]       load_word;

    logic [WIDTH-1:0]       tx_shift;
    logic [WIDTH-2:0]       rx_shift;
    logic [CNT_W-1:0]       bit_cnt;

    logic                   in_frame_bits;
    logic                   sample_en, last_bit, advance_en, frame_abort;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // sdi shares the sclk delay, so the value seen at a detected falling
    // edge is the one the master held while sclk fell.
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign in_frame_bits = (bit_cnt < CNT_W'(WIDTH));
    assign sample_en     = (state == SHIFT) && sclk_fall && !cs_rise && in_frame_bits;
    assign last_bit      = sample_en && (bit_cnt == CNT_W'(WIDTH - 1));
    assign advance_en    = (state == SHIFT) && sclk_rise && !cs_rise &&
                           (bit_cnt != '0) && in_frame_bits;
    assign frame_abort   = (state == SHIFT) && cs_rise &&
                           (bit_cnt != '0) && in_frame_bits;

    assign accept    = tx_valid && !hold_full;
    assign tx_ready  = ~hold_full;
    assign load_word = hold_full ? hold_data : '0;

    // Synchronise the SPI pins and keep one extra delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sdi_sync  <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a cs rising edge always wins and returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = LOAD;
            LOAD:    state_next = cs_rise ? IDLE : SHIFT;
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding register: a word accepted while LOAD empties it is kept for the next LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
        end else if (state == LOAD) begin
            hold_full <= 1'b0;
        end
    end

    // Transmit path: bit 0 is presented in LOAD, later bits on sclk rising edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift    <= '0;
            sdo         <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            case (state)
                LOAD: begin
                    tx_shift    <= load_word >> 1;
                    sdo         <= cs_rise ? 1'b0 : load_word[0];
                    tx_underrun <= ~hold_full;
                end
                SHIFT: begin
                    if (cs_rise) begin
                        sdo <= 1'b0;
                    end else if (advance_en) begin
                        sdo      <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                default: sdo <= 1'b0;
            endcase
        end
    end

    // Receive path: assemble LSB first, publish the word and flag aborted frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift  <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= frame_abort;
            if (state != SHIFT) begin
                bit_cnt <= '0;
            end else if (sample_en) begin
                bit_cnt  <= bit_cnt + CNT_W'(1);
                rx_shift <= {sdi_s, rx_shift[WIDTH-2:1]};
                if (last_bit) begin
                    rx_data  <= {sdi_s, rx_shift};
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a bit-banged SPI master at fclk/8, a valid/ready
// producer for tx words, and a word-level model of what each frame carries.
module tb_spi_slave_sync;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sclk, cs, sdi, sdo;
    logic [W-1:0] tx_data, rx_data;
    logic         tx_valid, tx_ready, rx_valid, tx_underrun, frame_err;

    spi_slave_sync #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs         (cs),
        .sdi        (sdi),
        .sdo        (sdo),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_underrun(tx_underrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] mosi;
        logic [W-1:0] tx;
        bit           pres;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_miso;
        int           exp_und;
    } vec_t;

    vec_t vecs[4];

    int checks = 0;
    int errors = 0;

    int win_underrun, win_ferr, tot_ferr, tot_rxv, tot_und;
    logic [W-1:0] got_rx[$];
    int           got_und[$];
    logic [W-1:0] got_miso[$];
    bit           got_ready0[$];

    logic [W-1:0] b_mosi[$];
    logic [W-1:0] b_tx[$];
    bit           b_pres[$];

    bit           tx_pend, acc_pending;
    logic [W-1:0] tx_pend_word;
    int           acc_cnt;
    logic [W-1:0] last_rx;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One system clock: observe pulses on the falling edge and run the tx handshake.
    task automatic tick();
        @(negedge clk);
        if (tx_underrun === 1'b1) begin
            win_underrun++;
            tot_und++;
        end
        if (frame_err === 1'b1) begin
            win_ferr++;
            tot_ferr++;
        end
        if (rx_valid === 1'b1) begin
            got_rx.push_back(rx_data);
            got_und.push_back(win_underrun);
            win_underrun = 0;
            tot_rxv++;
        end
        if (acc_pending) begin
            tx_valid    = 1'b0;
            acc_pending = 1'b0;
            acc_cnt++;
        end
        if (tx_pend && !tx_valid) begin
            tx_data  = tx_pend_word;
            tx_valid = 1'b1;
            tx_pend  = 1'b0;
        end
        if (tx_valid && tx_ready) acc_pending = 1'b1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Runs one cs-low burst of b_mosi.size() frames; word 0 is preloaded,
    // later words are offered during the previous frame (or on the LOAD cycle when early).
    task automatic applyStimulus(input bit early);
        int           n = b_mosi.size();
        int           npres = 0;
        logic [W-1:0] word, miso;
        got_rx.delete();
        got_und.delete();
        got_miso.delete();
        got_ready0.delete();
        acc_cnt = 0;
        foreach (b_pres[j]) if (b_pres[j]) npres++;
        if (b_pres[0]) begin
            tx_pend_word = b_tx[0];
            tx_pend      = 1'b1;
            for (int t = 0; t < 20 && (tx_pend || tx_valid); t++) tick();
        end
        cs           = 1'b0;
        win_underrun = 0;
        win_ferr     = 0;
        ticks(2);
        if (early && n > 1 && b_pres[1]) begin
            tx_pend_word = b_tx[1];
            tx_pend      = 1'b1;
        end
        ticks(6);
        for (int k = 0; k < n; k++) begin
            word = b_mosi[k];
            miso = '0;
            for (int i = 0; i < W; i++) begin
                if (i == 1 && k + 1 < n && b_pres[k+1] && !(early && k == 0)) begin
                    tx_pend_word = b_tx[k+1];
                    tx_pend      = 1'b1;
                end
                sdi  = word[i];
                sclk = 1'b1;
                ticks(4);
                miso[i] = sdo;
                if (i == 0) got_ready0.push_back(tx_ready);
                sclk = 1'b0;
                ticks(4);
            end
            got_miso.push_back(miso);
        end
        cs  = 1'b1;
        sdi = 1'b0;
        ticks(8);
        checkOutput("tx_accepted", acc_cnt, npres);
        checkOutput("sdo_idle", {31'd0, sdo}, 32'd0);
        checkOutput("frame_err_none", win_ferr, 0);
        checkOutput("rx_valid_count", got_rx.size(), n);
        tx_valid    = 1'b0;
        tx_pend     = 1'b0;
        acc_pending = 1'b0;
    endtask

    // Word-level expectation: each frame returns the master's word and
    // transmits the supplied word, or zeros with one underrun if none.
    task automatic verifyBurst(input string tag);
        for (int k = 0; k < b_mosi.size(); k++) begin
            if (k < got_rx.size()) begin
                checkOutput({tag, "_rx"}, got_rx[k], b_mosi[k]);
                checkOutput({tag, "_underrun"}, got_und[k], b_pres[k] ? 0 : 1);
            end
            checkOutput({tag, "_miso"}, got_miso[k], b_pres[k] ? b_tx[k] : '0);
        end
        last_rx = b_mosi[b_mosi.size()-1];
    endtask

    task automatic setBurst1(input logic [W-1:0] m, input logic [W-1:0] t, input bit p);
        b_mosi.delete(); b_tx.delete(); b_pres.delete();
        b_mosi.push_back(m); b_tx.push_back(t); b_pres.push_back(p);
    endtask

    task automatic sendBits(input logic [W-1:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sdi  = word[i];
            sclk = 1'b1;
            ticks(4);
            sclk = 1'b0;
            ticks(4);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sdo"}, {31'd0, sdo}, 32'd0);
        checkOutput({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
        checkOutput({tag, "_rx_data"}, rx_data, 0);
        checkOutput({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        checkOutput({tag, "_tx_underrun"}, {31'd0, tx_underrun}, 32'd0);
        checkOutput({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        int           s_rxv, s_ferr, s_und;
        logic [W-1:0] w;

        vecs[0] = '{mosi: 8'h3C, tx: 8'hA5, pres: 1'b1, exp_rx: 8'h3C, exp_miso: 8'hA5, exp_und: 0};
        vecs[1] = '{mosi: 8'hFF, tx: 8'h00, pres: 1'b0, exp_rx: 8'hFF, exp_miso: 8'h00, exp_und: 1};
        vecs[2] = '{mosi: 8'h00, tx: 8'hFF, pres: 1'b1, exp_rx: 8'h00, exp_miso: 8'hFF, exp_und: 0};
        vecs[3] = '{mosi: 8'h96, tx: 8'h01, pres: 1'b1, exp_rx: 8'h96, exp_miso: 8'h01, exp_und: 0};

        rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; sdi = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        tx_pend = 1'b0; acc_pending = 1'b0; acc_cnt = 0;
        win_underrun = 0; win_ferr = 0; tot_ferr = 0; tot_rxv = 0; tot_und = 0;
        last_rx = '0;
        ticks(3);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        ticks(4);

        // Single frames from the vector table.
        foreach (vecs[v]) begin
            setBurst1(vecs[v].mosi, vecs[v].tx, vecs[v].pres);
            applyStimulus(1'b0);
            if (got_rx.size() > 0) begin
                checkOutput("vec_rx", got_rx[0], vecs[v].exp_rx);
                checkOutput("vec_underrun", got_und[0], vecs[v].exp_und);
            end
            checkOutput("vec_miso", got_miso[0], vecs[v].exp_miso);
            checkOutput("vec_ready_after_load", {31'd0, got_ready0[0]}, 32'd1);
            last_rx = vecs[v].exp_rx;
        end

        // sclk toggling with cs high must not start or complete anything.
        s_rxv = tot_rxv;
        sendBits(8'hAA, 8);
        checkOutput("cs_high_no_rx", tot_rxv, s_rxv);
        checkOutput("cs_high_sdo", {31'd0, sdo}, 32'd0);

        // Back-to-back frames with cs held low.
        b_mosi = '{8'h12, 8'h34}; b_tx = '{8'h55, 8'hAA}; b_pres = '{1'b1, 1'b1};
        applyStimulus(1'b0);
        verifyBurst("b2b");

        // Second word offered on the LOAD cycle while the register is still full.
        b_mosi = '{8'h5A, 8'hC3}; b_tx = '{8'h11, 8'h22}; b_pres = '{1'b1, 1'b1};
        applyStimulus(1'b1);
        verifyBurst("load_collide");

        // cs raised after 5 bits.
        s_rxv = tot_rxv;
        cs = 1'b0; win_ferr = 0;
        ticks(8);
        sendBits(8'h1F, 5);
        cs = 1'b1; sdi = 1'b0;
        ticks(8);
        checkOutput("abort_frame_err", win_ferr, 1);
        checkOutput("abort_no_rx_valid", tot_rxv, s_rxv);
        checkOutput("abort_rx_hold", rx_data, last_rx);
        setBurst1(8'h81, 8'h00, 1'b0);
        applyStimulus(1'b0);
        verifyBurst("after_abort");

        // Reset pulsed after 3 bits; the master aborts too.
        cs = 1'b0;
        ticks(8);
        sendBits(8'hE7, 3);
        rst_n = 1'b0;
        s_rxv = tot_rxv; s_ferr = tot_ferr; s_und = tot_und;
        sclk = 1'b0; cs = 1'b1; sdi = 1'b0;
        ticks(1);
        checkResetOutputs("midreset");
        ticks(3);
        rst_n = 1'b1;
        ticks(10);
        checkOutput("midreset_no_rx_valid", tot_rxv, s_rxv);
        checkOutput("midreset_no_frame_err", tot_ferr, s_ferr);
        checkOutput("midreset_no_underrun", tot_und, s_und);
        last_rx = '0;
        setBurst1(8'h7E, 8'h3B, 1'b1);
        applyStimulus(1'b0);
        verifyBurst("after_reset");

        // Random bursts of 1..3 frames, words present or absent at random.
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 3);
            b_mosi.delete(); b_tx.delete(); b_pres.delete();
            for (int k = 0; k < n; k++) begin
                w = W'($urandom);
                b_mosi.push_back(w);
                w = W'($urandom);
                b_tx.push_back(w);
                b_pres.push_back(1'($urandom_range(0, 3) != 0));
            end
            applyStimulus(1'b0);
            verifyBurst("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
